// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types, register map and segment table for the 7-segment controller
package sevenseg_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_CTRL   = 2'd1,
      REG_DPMASK = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_BLANK_LSB  = 8;
   localparam int CTRL_BRIGHT_LSB = 16;

   localparam int IDX_W   = 3;
   localparam int SUB_W   = 16;
   localparam int FRAME_W = 16;

   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h30;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h79;
         4'h4: s = 7'h74;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h6F;
         4'h7: s = 7'h38;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h7C;
         4'hA: s = 7'h7E;
         4'hB: s = 7'h67;
         4'hC: s = 7'h0F;
         4'hD: s = 7'h73;
         4'hE: s = 7'h4F;
         default: s = 7'h4E;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] m;
      m = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// rtl/sevenseg_scan_timer.sv - PWM sub-phase, phase and digit-index counters with frame counting
module sevenseg_scan_timer
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SUB_DIV    = 240
)(
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_enable,
   output logic [3:0]         o_phase,
   output logic [IDX_W-1:0]   o_index,
   output logic               o_frame_start,
   output logic [FRAME_W-1:0] o_frame_cnt
);

   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   logic [SUB_W-1:0]   r_sub;
   logic [3:0]         r_phase;
   logic [IDX_W-1:0]   r_index;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic               w_sub_zero;
   logic               w_phase_wrap;
   logic               w_digit_wrap;

   assign w_sub_zero   = (r_sub == '0);
   assign w_phase_wrap = w_sub_zero && (r_phase == 4'hF);
   assign w_digit_wrap = w_phase_wrap && (r_index == '0);

   // Disabled scanning parks every counter at its reset value so re-enable starts a clean frame.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sub       <= SUB_MAX;
         r_phase     <= 4'd0;
         r_index     <= IDX_MAX;
         r_frame_cnt <= '0;
      end else if (!i_enable) begin
         r_sub   <= SUB_MAX;
         r_phase <= 4'd0;
         r_index <= IDX_MAX;
      end else begin
         r_sub <= w_sub_zero ? SUB_MAX : r_sub - SUB_W'(1);
         if (w_sub_zero)   r_phase     <= r_phase + 4'd1;
         if (w_phase_wrap) r_index     <= (r_index == '0) ? IDX_MAX : r_index - IDX_W'(1);
         if (w_digit_wrap) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
   end

   assign o_phase       = r_phase;
   assign o_index       = r_index;
   assign o_frame_start = i_enable && w_digit_wrap;
   assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: rtl/iomem_sevenseg_ctrl.sv
// rtl/iomem_sevenseg_ctrl.sv - picosoc iomem slave driving a multiplexed PWM 7-segment display
module iomem_sevenseg_ctrl
   import sevenseg_pkg::*;
#(
   parameter int         NUM_DIGITS   = 4,
   parameter int         SUB_DIV      = 240,
   parameter logic [7:0] BASE_ADDR    = 8'h05,
   parameter bit         COMM_ACT_LOW = 1'b1
)(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  iomem_valid,
   output logic                  iomem_ready,
   input  logic [3:0]            iomem_wstrb,
   input  logic [31:0]           iomem_addr,
   input  logic [31:0]           iomem_wdata,
   output logic [31:0]           iomem_rdata,
   output logic [NUM_DIGITS-1:0] comm,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int                    DW       = 4 * NUM_DIGITS;
   localparam logic [NUM_DIGITS-1:0] COMM_OFF = {NUM_DIGITS{COMM_ACT_LOW}};

   logic [DW-1:0]         r_data;
   logic [DW-1:0]         r_active;
   logic                  r_pending;
   logic                  r_enable;
   logic [7:0]            r_blank;
   logic [3:0]            r_bright;
   logic [7:0]            r_dpmask;
   logic                  r_ready;
   logic [31:0]           r_rdata;
   logic [NUM_DIGITS-1:0] r_comm;
   logic [6:0]            r_seg;
   logic                  r_dp;

   logic                  w_hit;
   logic                  w_wr;
   logic                  w_data_wr;
   logic                  w_copy;
   reg_sel_e              w_sel;
   logic [31:0]           w_data_ext;
   logic [31:0]           w_data_new;
   logic [31:0]           w_ctrl_rd;
   logic [31:0]           w_ctrl_new;
   logic [31:0]           w_dp_new;
   logic [31:0]           w_status_rd;
   logic [31:0]           w_rd_mux;
   logic [3:0]            w_phase;
   logic [IDX_W-1:0]      w_index;
   logic                  w_frame_start;
   logic [FRAME_W-1:0]    w_frame_cnt;
   logic [3:0]            w_nib;
   logic                  w_on;
   logic [NUM_DIGITS-1:0] w_onehot;
   logic                  w_unused;

   sevenseg_scan_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .SUB_DIV    (SUB_DIV)
   ) u_timer (
      .clk           (clk),
      .resetn        (resetn),
      .i_enable      (r_enable),
      .o_phase       (w_phase),
      .o_index       (w_index),
      .o_frame_start (w_frame_start),
      .o_frame_cnt   (w_frame_cnt)
   );

   // Masking with ready keeps a held request from being acknowledged on consecutive cycles.
   assign w_hit     = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_ADDR);
   assign w_wr      = w_hit && (iomem_wstrb != 4'b0000);
   assign w_sel     = reg_sel_e'(iomem_addr[3:2]);
   assign w_data_wr = w_wr && (w_sel == REG_DATA);
   assign w_copy    = w_frame_start || (!r_enable && r_pending);

   always_comb begin
      w_data_ext = '0;
      w_data_ext[DW-1:0] = r_data;
   end

   assign w_ctrl_rd   = {12'd0, r_bright, r_blank, 7'd0, r_enable};
   assign w_status_rd = {w_frame_cnt, 5'd0, w_index, 7'd0, r_pending};
   assign w_data_new  = byte_merge(w_data_ext, iomem_wdata, iomem_wstrb);
   assign w_ctrl_new  = byte_merge(w_ctrl_rd, iomem_wdata, iomem_wstrb);
   assign w_dp_new    = byte_merge({24'd0, r_dpmask}, iomem_wdata, iomem_wstrb);

   always_comb begin
      w_rd_mux = '0;
      case (w_sel)
         REG_DATA:   w_rd_mux = w_data_ext;
         REG_CTRL:   w_rd_mux = w_ctrl_rd;
         REG_DPMASK: w_rd_mux = {24'd0, r_dpmask};
         REG_STATUS: w_rd_mux = w_status_rd;
         default:    w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready   <= 1'b0;
         r_rdata   <= '0;
         r_data    <= '0;
         r_active  <= '0;
         r_pending <= 1'b0;
         r_enable  <= 1'b1;
         r_blank   <= 8'd0;
         r_bright  <= 4'hF;
         r_dpmask  <= 8'd0;
      end else begin
         r_ready <= w_hit;
         r_rdata <= w_hit ? w_rd_mux : '0;
         if (w_data_wr) r_data <= w_data_new[DW-1:0];
         if (w_wr && (w_sel == REG_CTRL)) begin
            r_enable <= w_ctrl_new[CTRL_EN_BIT];
            r_blank  <= w_ctrl_new[CTRL_BLANK_LSB +: 8];
            r_bright <= w_ctrl_new[CTRL_BRIGHT_LSB +: 4];
         end
         if (w_wr && (w_sel == REG_DPMASK)) r_dpmask <= w_dp_new[7:0];
         // A write colliding with the copy takes priority on pending, so it waits for the next frame.
         if (w_copy) r_active <= r_data;
         if (w_data_wr)   r_pending <= 1'b1;
         else if (w_copy) r_pending <= 1'b0;
      end
   end

   always_comb begin
      w_nib    = 4'(r_active >> {w_index, 2'b00});
      w_on     = r_enable && !r_blank[w_index] && (w_phase <= r_bright);
      w_onehot = '0;
      w_onehot[0] = 1'b1;
      w_onehot = w_onehot << w_index;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_comm <= COMM_OFF;
         r_seg  <= 7'd0;
         r_dp   <= 1'b0;
      end else begin
         r_comm <= w_on ? (w_onehot ^ COMM_OFF) : COMM_OFF;
         r_seg  <= w_on ? hex2seg(w_nib) : 7'd0;
         r_dp   <= w_on && r_dpmask[w_index];
      end
   end

   assign iomem_ready = r_ready;
   assign iomem_rdata = r_rdata;
   assign comm        = r_comm;
   assign seg         = r_seg;
   assign dp          = r_dp;

   assign w_unused = ^{iomem_addr[23:4], iomem_addr[1:0], w_data_new, w_ctrl_new, w_dp_new};

endmodule

// File: tb/tb_iomem_sevenseg_ctrl.sv
// tb/tb_iomem_sevenseg_ctrl.sv - scoreboard bench for the iomem 7-segment controller
module tb_iomem_sevenseg_ctrl;

   localparam int SUB  = 16;
   localparam int SLOT = 16 * SUB;
   localparam int LIM  = SLOT + 8;
   localparam logic [3:0] D3 = 4'b0111, D2 = 4'b1011, D1 = 4'b1101, D0 = 4'b1110, OFF = 4'b1111;
   localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_DP = 2'd2, A_STAT = 2'd3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'd0;
   logic [31:0] iomem_addr = 32'd0;
   logic [31:0] iomem_wdata = 32'd0;
   logic [31:0] iomem_rdata;
   logic [3:0]  comm;
   logic [6:0]  seg;
   logic        dp;

   typedef struct {
      bit          is_rd;
      logic [31:0] exp;
      logic [31:0] mask;
      string       name;
   } sb_t;

   sb_t sb_q[$];
   int  vectors = 0;
   int  miscompares = 0;
   int  c_on, c_d0, c_d1, c_d2, c_d3, c_dp, c_dpbad;

   always #5 clk = ~clk;

   iomem_sevenseg_ctrl #(
      .NUM_DIGITS   (4),
      .SUB_DIV      (SUB),
      .BASE_ADDR    (8'h05),
      .COMM_ACT_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .comm        (comm),
      .seg         (seg),
      .dp          (dp)
   );

   always @(posedge clk) begin
      sb_t e;
      #1;
      if (iomem_ready) begin
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL stray_ready: ready=1 with no request outstanding at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            if (e.is_rd) begin
               vectors++;
               if ((iomem_rdata & e.mask) !== (e.exp & e.mask)) begin
                  miscompares++;
                  $display("FAIL %s: rdata=%h expected %h (mask %h)", e.name, iomem_rdata, e.exp, e.mask);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit is_rd, input logic [31:0] exp, input logic [31:0] mask, input string name);
      sb_t e;
      e.is_rd = is_rd; e.exp = exp; e.mask = mask; e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic bus(input logic [1:0] r, input logic [31:0] wd, input logic [3:0] strb,
                      input logic [31:0] exp, input logic [31:0] mask, input string name);
      int n;
      push_exp(strb == 4'd0, exp, mask, name);
      iomem_valid = 1'b1;
      iomem_addr  = {8'h05, 20'h0, r, 2'b00};
      iomem_wdata = wd;
      iomem_wstrb = strb;
      n = 0;
      do begin @(negedge clk); n++; end while (!iomem_ready && n < 4);
      if (!iomem_ready) begin
         vectors++; miscompares++;
         $display("FAIL %s_ready_timeout: no ready after %0d cycles", name, n);
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] strb);
      bus(r, d, strb, 32'd0, 32'd0, "wr");
   endtask

   task automatic rd(input logic [1:0] r, input logic [31:0] exp, input logic [31:0] mask, input string name);
      bus(r, 32'd0, 4'd0, exp, mask, name);
   endtask

   task automatic step(input string name, input logic [3:0] exp_comm, input logic [6:0] exp_seg, input int exp_n);
      logic [3:0] prev;
      int n;
      prev = comm;
      n = 0;
      do begin @(negedge clk); n++; end while (comm == prev && n < LIM);
      chk({name, "_comm"}, 32'(comm), 32'(exp_comm));
      chk({name, "_seg"}, 32'(seg), 32'(exp_seg));
      if (exp_n > 0) chk({name, "_cycles"}, n, exp_n);
   endtask

   task automatic count_win(input int len);
      c_on = 0; c_d0 = 0; c_d1 = 0; c_d2 = 0; c_d3 = 0; c_dp = 0; c_dpbad = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (comm != OFF) c_on++;
         if (comm == D0) c_d0++;
         if (comm == D1) c_d1++;
         if (comm == D2) c_d2++;
         if (comm == D3) c_d3++;
         if (dp) c_dp++;
         if (dp && comm != D1) c_dpbad++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_first_comm", 32'(comm), 32'(D3));
      chk("rst_first_seg", 32'(seg), 32'h3F);
      chk("rst_first_dp", 32'(dp), 32'd0);
      step("t1_d2", D2, 7'h3F, SLOT);
      step("t1_d1", D1, 7'h3F, SLOT);
      step("t1_d0", D0, 7'h3F, SLOT);
      step("t1_d3", D3, 7'h3F, SLOT);

      wr(A_DATA, 32'h0000_1234, 4'hF);
      rd(A_STAT, 32'h0001_0001, 32'hFFFF_0001, "t2_stat_pending");
      step("t2_old_d2", D2, 7'h3F, 0);
      step("t2_old_d1", D1, 7'h3F, 0);
      step("t2_old_d0", D0, 7'h3F, 0);
      step("t2_new_d3", D3, 7'h30, 0);
      rd(A_STAT, 32'h0002_0000, 32'hFFFF_0001, "t2_stat_copied");
      step("t2_new_d2", D2, 7'h5B, 0);
      step("t2_new_d1", D1, 7'h79, 0);
      step("t2_new_d0", D0, 7'h74, 0);

      wr(A_DATA, 32'hAABB_CCDD, 4'b0001);
      rd(A_DATA, 32'h0000_12DD, 32'hFFFF_FFFF, "t5_strb_byte0");
      wr(A_DATA, 32'hFFFF_5678, 4'hF);
      rd(A_DATA, 32'h0000_5678, 32'hFFFF_FFFF, "t5_unused_bits_zero");
      push_exp(1'b1, 32'h000F_0001, 32'hFFFF_FFFF, "t5_b2b_rd0");
      push_exp(1'b1, 32'h000F_0001, 32'hFFFF_FFFF, "t5_b2b_rd1");
      iomem_valid = 1'b1;
      iomem_addr  = {8'h05, 20'h0, A_CTRL, 2'b00};
      iomem_wstrb = 4'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t5_b2b_ready%0d", i), 32'(iomem_ready), 32'(i % 2 == 0));
      end
      iomem_valid = 1'b0;
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0600_0004;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t5_nohit_ready%0d", i), 32'(iomem_ready), 32'd0);
      end
      iomem_valid = 1'b0;
      @(negedge clk);

      wr(A_CTRL, 32'h0003_0001, 4'hF);
      count_win(SLOT);
      chk("t3_bright3_on", c_on, 4 * SUB);
      wr(A_CTRL, 32'h0000_0001, 4'hF);
      count_win(SLOT);
      chk("t3_bright0_on", c_on, SUB);

      wr(A_DP, 32'h0000_0002, 4'hF);
      wr(A_CTRL, 32'h000F_0501, 4'hF);
      count_win(4 * SLOT);
      chk("t4_d0_blanked", c_d0, 0);
      chk("t4_d2_blanked", c_d2, 0);
      chk("t4_d1_on", c_d1, SLOT);
      chk("t4_d3_on", c_d3, SLOT);
      chk("t4_dp_count", c_dp, SLOT);
      chk("t4_dp_outside_d1", c_dpbad, 0);

      wr(A_CTRL, 32'h0000_0000, 4'hF);
      chk("en0_comm_off", 32'(comm), 32'(OFF));
      chk("en0_seg_zero", 32'(seg), 32'd0);
      wr(A_DATA, 32'h0000_ABCD, 4'hF);
      rd(A_STAT, 32'h0000_0300, 32'h0000_0701, "en0_stat_copied_idx3");
      wr(A_CTRL, 32'h000F_0001, 4'hF);
      chk("en1_comm_d3", 32'(comm), 32'(D3));
      chk("en1_seg_A", 32'(seg), 32'h7E);
      step("en1_d2", D2, 7'h67, SLOT);

      iomem_valid = 1'b1;
      iomem_addr  = {8'h05, 20'h0, A_DATA, 2'b00};
      iomem_wstrb = 4'd0;
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_comm", 32'(comm), 32'(OFF));
      chk("t6_rst_seg", 32'(seg), 32'd0);
      chk("t6_rst_dp", 32'(dp), 32'd0);
      chk("t6_rst_ready", 32'(iomem_ready), 32'd0);
      chk("t6_rst_rdata", iomem_rdata, 32'd0);
      @(negedge clk);
      iomem_valid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("t6_rel_comm", 32'(comm), 32'(D3));
      chk("t6_rel_seg", 32'(seg), 32'h3F);
      repeat (4) @(negedge clk);
      rd(A_DATA, 32'h0000_0000, 32'hFFFF_FFFF, "t6_data_reset");
      rd(A_CTRL, 32'h000F_0001, 32'hFFFF_FFFF, "t6_ctrl_reset");
      rd(A_DP, 32'h0000_0000, 32'hFFFF_FFFF, "t6_dpmask_reset");
      rd(A_STAT, 32'h0000_0300, 32'hFFFF_FFFF, "t6_status_reset");

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
